// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin, message-granular arbiter that shares one UART transmit
// controller among NUM_REQ byte-stream requesters. A grant is held from a
// source's first byte up to and including the byte flagged "last", so
// messages from different sources are never interleaved. Each byte is paced
// on the transmitter's ready-low / ready-high cycle.
//
// Optional feature: define UART_ARB_TIMEOUT_EN to revoke a grant whose owner
// stops presenting bytes for TIMEOUT_CYCLES FETCH cycles. Without the macro
// FETCH waits indefinitely and timeout_err is held at 0.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [8*NUM_REQ-1:0]     req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     uart_send,
    output logic [7:0]               uart_data,
    input  logic                     uart_ready,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_RDY_LOW  = 2'd2,
        ST_WAIT_RDY = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [PTR_W-1:0]   ptr_r;
    logic [PTR_W-1:0]   cur_r;
    logic [PTR_W-1:0]   win_s;
    logic               last_flag_r;

    logic               any_req_s;
    logic               cur_valid_s;
    logic               cur_last_s;
    logic [7:0]         cur_data_s;
    logic               start_s;
    logic               xfer_s;
    logic               msg_done_s;
    logic               abort_s;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Index following idx, wrapping NUM_REQ-1 back to 0 (NUM_REQ need not be
    // a power of two, so plain overflow is not enough).
    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
        logic [PTR_W-1:0] nxt;
        if (int'(idx) == NUM_REQ - 1) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = idx + PTR_W'(1'b1);
        end
        return nxt;
    endfunction

    // First requester with valid set, scanning start, start+1, ... modulo
    // NUM_REQ. Scanning from the far end lets the closest hit win last.
    function automatic logic [PTR_W-1:0] pick_winner(
        input logic [NUM_REQ-1:0] valid,
        input logic [PTR_W-1:0]   start
    );
        logic [PTR_W-1:0] win;
        int               idx;
        win = start;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % NUM_REQ;
            if (valid[idx]) begin
                win = PTR_W'(idx);
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

    // One-hot vector with bit idx set.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // -------------------------------------------------------------------------
    // Current-owner view and handshake qualifiers
    // -------------------------------------------------------------------------
    assign any_req_s   = |req_valid;
    assign win_s       = pick_winner(req_valid, ptr_r);
    assign cur_valid_s = req_valid[cur_r];
    assign cur_last_s  = req_last[cur_r];
    assign cur_data_s  = req_data[{cur_r, 3'b000} +: 8];

    // A new owner is only picked while the transmitter is idle, which also
    // covers a byte still shifting out after a mid-message reset.
    assign start_s    = (state_r == ST_IDLE) && uart_ready && any_req_s;
    assign xfer_s     = (state_r == ST_FETCH) && cur_valid_s && uart_ready;
    assign msg_done_s = (state_r == ST_WAIT_RDY) && uart_ready && last_flag_r;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_r;

    // The cycle that would bring the idle count to TIMEOUT_CYCLES revokes
    // the grant instead of counting.
    assign abort_s = (state_r == ST_FETCH) && !cur_valid_s &&
                     (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count FETCH cycles in which the owner presents nothing; clear on
    // transfer or on leaving FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r != ST_FETCH) || xfer_s || abort_s) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else if (!cur_valid_s) begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1'b1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end
`else
    logic unused_tmo_cfg_s;

    assign abort_s          = 1'b0;
    assign unused_tmo_cfg_s = (TIMEOUT_CYCLES > 0);
`endif

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: one byte per FETCH/RDY_LOW/WAIT_RDY round, back to
    // IDLE only after the last byte has fully left the transmitter.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (xfer_s) begin
                    state_nxt_s = ST_RDY_LOW;
                end else if (abort_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_RDY_LOW: begin
                if (!uart_ready) begin
                    state_nxt_s = ST_WAIT_RDY;
                end else begin
                    state_nxt_s = ST_RDY_LOW;
                end
            end
            ST_WAIT_RDY: begin
                if (uart_ready) begin
                    if (last_flag_r) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end else begin
                    state_nxt_s = ST_WAIT_RDY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: only the owner is offered ready, and only in FETCH while
    // the transmitter can take a byte.
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        if (state_r == ST_FETCH) begin
            req_ready[cur_r] = uart_ready;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // -------------------------------------------------------------------------
    // Registered datapath and status outputs
    // -------------------------------------------------------------------------

    // Grant ownership and rotate pointer: take ownership on start, release
    // after the last byte or a timeout and move the pointer past the owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant <= {NUM_REQ{1'b0}};
            cur_r <= {PTR_W{1'b0}};
            ptr_r <= {PTR_W{1'b0}};
        end else if (start_s) begin
            grant <= onehot(win_s);
            cur_r <= win_s;
            ptr_r <= ptr_r;
        end else if (msg_done_s || abort_s) begin
            grant <= {NUM_REQ{1'b0}};
            cur_r <= cur_r;
            ptr_r <= next_idx(cur_r);
        end else begin
            grant <= grant;
            cur_r <= cur_r;
            ptr_r <= ptr_r;
        end
    end

    // Byte capture: latch the accepted byte and its last flag; the byte stays
    // on uart_data after the one-cycle send strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            uart_send   <= 1'b0;
            uart_data   <= 8'h00;
            last_flag_r <= 1'b0;
        end else if (xfer_s) begin
            uart_send   <= 1'b1;
            uart_data   <= cur_data_s;
            last_flag_r <= cur_last_s;
        end else begin
            uart_send   <= 1'b0;
            uart_data   <= uart_data;
            last_flag_r <= last_flag_r;
        end
    end

    // Status flags: busy mirrors "not IDLE" as a flop; timeout_err pulses on
    // the revoking edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            busy        <= (state_nxt_s != ST_IDLE);
            timeout_err <= abort_s;
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin, message-granular arbiter that shares one UART transmit controller among `NUM_REQ` byte-stream requesters. It sits between message sources (button/status/string generators) and the UART transmitter's `send`/`data`/`ready` handshake. It holds a grant from a source's first byte to the byte flagged `last`, so messages are never interleaved. It paces each byte on the transmitter's ready-low/ready-high cycle.

## Interface
- `NUM_REQ`, 4, number of requesters; legal range 2..8.
- `TIMEOUT_CYCLES`, 1024, idle-cycle limit for a granted requester; used only with `UART_ARB_TIMEOUT_EN`.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  bit i: requester i presents a byte.
- `req_data`  in  8*NUM_REQ  requester i byte on bits [8i+7:8i].
- `req_last`  in  NUM_REQ  bit i: presented byte is the final byte of i's message.
- `req_ready`  out  NUM_REQ  bit i: byte accepted this cycle; combinational; transfer occurs when `req_valid[i] && req_ready[i]`.
- `grant`  out  NUM_REQ  one-hot registered grant; all-zero when idle.
- `uart_send`  out  1  one-cycle send strobe to the transmitter.
- `uart_data`  out  8  byte to the transmitter; valid while `uart_send` is high and held afterwards.
- `uart_ready`  in  1  transmitter ready; low while a byte is being shifted out.
- `busy`  out  1  high whenever state is not IDLE.
- `timeout_err`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- Reset values: state IDLE, `grant`=0, `uart_send`=0, `uart_data`=0x00, `busy`=0, `timeout_err`=0, rotate pointer `ptr`=0, timeout counter=0.
- **IDLE**
  - Entry condition: `uart_ready`=1 and any `req_valid`.
  - Winner: first set bit scanning `ptr`, `ptr`+1, … modulo NUM_REQ.
  - Actions: register `grant`=onehot(winner) and `cur`=winner, then go to FETCH.
  - If `uart_ready`=0, stay in IDLE regardless of requests.
- **FETCH**
  - `req_ready[cur]` = `uart_ready`; all other `req_ready` bits are 0.
  - On transfer: register `uart_data`=byte, `uart_send`=1, `last_flag`=`req_last[cur]`, then go to RDY_LOW.
- **RDY_LOW**
  - `uart_send` is high only in the first cycle of this state.
  - Stay until `uart_ready`=0, then go to WAIT_RDY.
- **WAIT_RDY**
  - Stay until `uart_ready`=1.
  - If `last_flag`=1: `grant`←0, `ptr`←(`cur`+1) mod NUM_REQ, go to IDLE.
  - If `last_flag`=0: go to FETCH.
- Valid/data of non-granted requesters are ignored. They must hold their request, since `req_ready` stays 0 for them.
- `ptr`/`cur` width is clog2(NUM_REQ). The wrap from NUM_REQ-1 returns to 0.
- A requester that raises `req_valid` while another holds the grant is served no earlier than the holder's `last` byte completes.
- Reset mid-operation:
  - All state returns to reset values on the next edge, and the partial message is abandoned.
  - The transmitter is not reset. The IDLE `uart_ready` check prevents a new send until any in-flight byte finishes.

## Timing
- Request to grant: 1 cycle (IDLE sampling edge).
- Grant to earliest `req_ready`: same cycle that FETCH is entered.
- Transfer to `uart_send` high: 1 cycle (registered); `uart_send` is never high for two consecutive cycles.
- Per-byte overhead beyond transmitter time: 3 cycles (FETCH, RDY_LOW, WAIT_RDY exit).
- Message end to next grant: `grant` drops 1 cycle after `uart_ready` rises in WAIT_RDY. The next grant is registered one cycle later, so there is at least one all-zero `grant` cycle between owners.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - The counter increments in each FETCH cycle with `req_valid[cur]`=0 and clears on transfer or state exit.
  - On reaching `TIMEOUT_CYCLES`, the block pulses `timeout_err` for 1 cycle and clears `grant`.
  - It also sets `ptr`←`cur`+1 and returns to IDLE; the partial message is dropped.
- `UART_ARB_TIMEOUT_EN` not defined:
  - FETCH waits indefinitely and no counter logic exists.
  - `timeout_err` is tied to 0 and `TIMEOUT_CYCLES` is ignored.

## Test plan
- Single requester: after reset, requester 0 sends 0x48, 0x69, 0x0A (last), with a transmitter model of ready low for 10 cycles per byte. Required: three `uart_send` pulses carrying those bytes in order, `grant`=0001 throughout, and `grant`=0000 plus `busy`=0 after the third ready rise.
- Contention, no interleave: requesters 0 and 2 both valid in IDLE with `ptr`=0, each with a 2-byte message. Required: both bytes from 0 go out, then both bytes from 2; `req_ready[2]` stays 0 until `grant`=0100.
- Fairness: all 4 requesters continuously present 1-byte messages (0xA0+i). Required: byte sequence 0xA0, A1, A2, A3, A0, and `ptr` wraps 3→0.
- Late arrival: requester 1 raises valid during requester 3's second byte. Required: requester 3 finishes its last byte, then requester 1 is granted with no other owner in between.
- Timeout (macro on, `TIMEOUT_CYCLES`=16): requester 0 sends one non-last byte, then drops valid while requester 1 is valid. Required: after 16 FETCH cycles `timeout_err` pulses once, `grant` goes 0001→0000→0010, and requester 1's byte is sent.
- Reset mid-message: assert `rst` in WAIT_RDY with `uart_ready`=0. Required: next cycle `grant`=0, `uart_send`=0, `busy`=0; no new `uart_send` until `uart_ready` returns to 1.
